// File: rtl/sr_cmd_sequencer.sv
// Button-to-latch command sequencer: debounces set/reset buttons, issues exclusive
// fixed-width S/R pulses to a NOR SR latch, then verifies the latch Q/Qn readback.
module sr_cmd_sequencer #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    input  logic q_fb,
    input  logic qn_fb,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic conflict,
    output logic err,
    output logic last_cmd
);

    localparam int unsigned CNT_W        = 8;
    localparam int unsigned CHECK_CYCLES = 3;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE_S = 3'd1,
        DRIVE_R = 3'd2,
        GAP     = 3'd3,
        CHECK   = 3'd4
    } state_t;

    // Synchroniser bit order: {qn_fb, q_fb, btn_reset, btn_set}
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [1:0]            r_deb;
    logic [1:0]            r_deb_d;
    logic [1:0][CNT_W-1:0] r_deb_cnt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last_cmd;
    logic             w_last_cmd_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_conflict_nxt;
    logic             r_s_out;
    logic             r_r_out;
    logic             r_busy;
    logic             r_conflict;

    logic       w_set_req;
    logic       w_reset_req;
    logic [1:0] w_readback;
    logic [1:0] w_expect;

    assign w_set_req   = r_deb[0] & ~r_deb_d[0];
    assign w_reset_req = r_deb[1] & ~r_deb_d[1];
    assign w_readback  = {r_sync2[2], r_sync2[3]};
    assign w_expect    = r_last_cmd ? 2'b10 : 2'b01;

    // Input synchronisers and per-button debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_deb     <= '0;
            r_deb_d   <= '0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= {qn_fb, q_fb, btn_reset, btn_set};
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // FSM state and registered outputs; outputs derive from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_cmd <= 1'b0;
            r_err      <= 1'b0;
            r_s_out    <= 1'b0;
            r_r_out    <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_cmd <= w_last_cmd_nxt;
            r_err      <= w_err_nxt;
            r_s_out    <= (w_state_nxt == DRIVE_S);
            r_r_out    <= (w_state_nxt == DRIVE_R);
            r_busy     <= (w_state_nxt != IDLE);
            r_conflict <= w_conflict_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_last_cmd_nxt = r_last_cmd;
        w_err_nxt      = r_err;
        w_conflict_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_set_req && w_reset_req) begin
                    w_conflict_nxt = 1'b1;
                end else if (w_set_req) begin
                    w_state_nxt    = DRIVE_S;
                    w_last_cmd_nxt = 1'b1;
                end else if (w_reset_req) begin
                    w_state_nxt    = DRIVE_R;
                    w_last_cmd_nxt = 1'b0;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                // Readback is only trusted once the synchroniser has caught up
                if (r_cnt == CHECK_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    if (w_readback != w_expect) begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign s_out    = r_s_out;
    assign r_out    = r_r_out;
    assign busy     = r_busy;
    assign conflict = r_conflict;
    assign err      = r_err;
    assign last_cmd = r_last_cmd;

endmodule
